// File: rtl/myproject_dense_acc.sv
// myproject_dense_acc: accumulates bias + N_TERMS signed products for one output neuron.
// It then rounds half-up, drops FRAC_SHIFT LSBs and saturates to OUT_WIDTH.
// The result is handed downstream over a valid/ready handshake.
// Build option: define MYPROJECT_DENSE_ACC_RELU_EN to clamp negative results to zero.
module myproject_dense_acc #(
  parameter int PROD_WIDTH = 25,
  parameter int ACC_WIDTH  = 32,
  parameter int N_TERMS    = 16,
  parameter int BIAS_WIDTH = 16,
  parameter int FRAC_SHIFT = 9,
  parameter int OUT_WIDTH  = 16
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic [PROD_WIDTH-1:0] prod_data,
  input  logic                  prod_valid,
  output logic                  prod_ready,
  input  logic [BIAS_WIDTH-1:0] bias,
  output logic [OUT_WIDTH-1:0]  res_data,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic                  res_sat,
  output logic                  busy
);

  localparam int CNT_W = $clog2(N_TERMS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);
  localparam logic signed [ACC_WIDTH-1:0] ROUND_ADD = ACC_WIDTH'(64'sd1 <<< (FRAC_SHIFT - 1));
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_t;

  state_t                      state_reg, state_next;
  logic [CNT_W-1:0]            cnt_reg;
  logic signed [ACC_WIDTH-1:0] acc_reg;
  logic [OUT_WIDTH-1:0]        res_data_reg;
  logic                        res_valid_reg;
  logic                        res_sat_reg;

  logic signed [ACC_WIDTH-1:0] bias_ext, prod_ext, acc_base, acc_sum, rounded, scaled;
  logic [OUT_WIDTH-1:0]        sat_data;
  logic                        sat_flag;
  logic                        prod_take, res_take, is_last;

  // prod_ready is a function of state (and reset) only, never of res_ready
  assign prod_ready = (state_reg != OUT) && !ap_rst;
  assign prod_take  = prod_valid && prod_ready;
  assign res_take   = res_valid_reg && res_ready;
  // cnt holds the number of products already taken; it is 0 in IDLE
  assign is_last    = (state_reg != OUT) && (cnt_reg == LAST_CNT);

  assign bias_ext = {{(ACC_WIDTH-BIAS_WIDTH){bias[BIAS_WIDTH-1]}}, bias};
  assign prod_ext = {{(ACC_WIDTH-PROD_WIDTH){prod_data[PROD_WIDTH-1]}}, prod_data};
  assign acc_base = (state_reg == IDLE) ? bias_ext : acc_reg;
  assign acc_sum  = acc_base + prod_ext;
  assign rounded  = acc_sum + ROUND_ADD;
  assign scaled   = rounded >>> FRAC_SHIFT;

  // Clip the rescaled sum to the output range (ReLU variant clamps negatives silently)
  always_comb begin
    sat_data = scaled[OUT_WIDTH-1:0];
    sat_flag = 1'b0;
`ifdef MYPROJECT_DENSE_ACC_RELU_EN
    if (scaled[ACC_WIDTH-1]) begin
      sat_data = '0;
    end else if (scaled > SAT_MAX) begin
      sat_data = SAT_MAX[OUT_WIDTH-1:0];
      sat_flag = 1'b1;
    end
`else
    if (scaled > SAT_MAX) begin
      sat_data = SAT_MAX[OUT_WIDTH-1:0];
      sat_flag = 1'b1;
    end else if (scaled < SAT_MIN) begin
      sat_data = SAT_MIN[OUT_WIDTH-1:0];
      sat_flag = 1'b1;
    end
`endif
  end

  // Next-state logic and status outputs
  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (prod_take) state_next = is_last ? OUT : ACCUM;
      end
      ACCUM: begin
        busy = 1'b1;
        if (prod_take && is_last) state_next = OUT;
      end
      OUT: begin
        busy = 1'b1;
        if (res_take) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Accumulator, term counter and registered result
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      acc_reg       <= '0;
      cnt_reg       <= '0;
      res_data_reg  <= '0;
      res_valid_reg <= 1'b0;
      res_sat_reg   <= 1'b0;
    end else begin
      if (prod_take) begin
        acc_reg <= acc_sum;
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
      if (prod_take && is_last) begin
        res_data_reg  <= sat_data;
        res_sat_reg   <= sat_flag;
        res_valid_reg <= 1'b1;
      end else if (res_take) begin
        res_valid_reg <= 1'b0;
        cnt_reg       <= '0;
      end
    end
  end

  assign res_data  = res_data_reg;
  assign res_valid = res_valid_reg;
  assign res_sat   = res_sat_reg;

endmodule

// File: tb/tb_myproject_dense_acc.sv
// Randomized self-checking bench for myproject_dense_acc (default parameters).
// Expected results come from plain integer arithmetic over a whole group.
module tb_myproject_dense_acc;
  localparam int N = 16;

  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic [24:0] prod_data;
  logic        prod_valid;
  logic        prod_ready;
  logic [15:0] bias;
  logic [15:0] res_data;
  logic        res_valid;
  logic        res_ready;
  logic        res_sat;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;
  int prods[N];

  myproject_dense_acc dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .prod_data(prod_data), .prod_valid(prod_valid), .prod_ready(prod_ready),
    .bias(bias),
    .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
    .res_sat(res_sat), .busy(busy)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic check_value(input string tag, input longint obs, input longint exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Whole-group reference: exact sum, floor((sum + 256) / 512), then clip
  function automatic void model(input longint b, output longint d, output longint s);
    longint sum;
    longint q;
    sum = b;
    foreach (prods[i]) sum += longint'(prods[i]);
    q = (sum + 256) >>> 9;
    d = q;
    s = 0;
`ifdef MYPROJECT_DENSE_ACC_RELU_EN
    if (q < 0) d = 0;
    else if (q > 32767) begin d = 32767; s = 1; end
`else
    if (q > 32767) begin d = 32767; s = 1; end
    else if (q < -32768) begin d = -32768; s = 1; end
`endif
  endfunction

  // Offer one product; returns #1 after the edge on which it was taken
  task automatic send(input int p, input logic [15:0] b);
    int guard = 0;
    prod_data  = 25'(p);
    bias       = b;
    prod_valid = 1'b1;
    while (!prod_ready && guard < 20) begin
      @(posedge ap_clk); #1;
      guard++;
    end
    if (guard >= 20) check_value("ready_timeout", 0, 1);
    @(posedge ap_clk); #1;
    prod_valid = 1'b0;
    prod_data  = 25'($urandom);
    bias       = 16'($urandom);
  endtask

  task automatic run_group(input longint b, input int gap_pct, input int hold);
    longint ed, es;
    model(b, ed, es);
    res_ready = (hold == 0);
    for (int i = 0; i < N; i++) begin
      if (int'($urandom_range(99)) < gap_pct) begin
        prod_valid = 1'b0;
        repeat ($urandom_range(1, 3)) begin
          @(posedge ap_clk); #1;
        end
        check_value("busy_gap", longint'(busy), (i > 0) ? 1 : 0);
      end
      if (i == N - 1) check_value("early_valid", longint'(res_valid), 0);
      send(prods[i], (i == 0) ? 16'(b) : 16'($urandom));
    end
    check_value("res_valid", longint'(res_valid), 1);
    check_value("res_data", longint'($signed(res_data)), ed);
    check_value("res_sat", longint'(res_sat), es);
    check_value("ready_out", longint'(prod_ready), 0);
    for (int k = 0; k < hold; k++) begin
      prod_valid = 1'b1;
      prod_data  = 25'($urandom);
      @(posedge ap_clk); #1;
      check_value("hold_valid", longint'(res_valid), 1);
      check_value("hold_data", longint'($signed(res_data)), ed);
      check_value("hold_ready", longint'(prod_ready), 0);
    end
    prod_valid = 1'b0;
    res_ready  = 1'b1;
    @(posedge ap_clk); #1;
    check_value("rel_valid", longint'(res_valid), 0);
    check_value("rel_ready", longint'(prod_ready), 1);
    check_value("rel_busy", longint'(busy), 0);
  endtask

  task automatic fill(input int v);
    foreach (prods[i]) prods[i] = v;
  endtask

  initial begin
    logic [15:0] rb;
    int range_sel, rng;

    ap_rst = 1'b1; prod_data = '0; prod_valid = 1'b0; bias = '0; res_ready = 1'b1;
    repeat (2) @(posedge ap_clk);
    #1;
    check_value("rst_ready", longint'(prod_ready), 0);
    check_value("rst_busy", longint'(busy), 0);
    check_value("rst_valid", longint'(res_valid), 0);
    check_value("rst_data", longint'(res_data), 0);
    check_value("rst_sat", longint'(res_sat), 0);
    ap_rst = 1'b0;
    #1;
    check_value("post_rst_ready", longint'(prod_ready), 1);

    // Basic sum and rounding corners
    fill(512);      run_group(0, 0, 0);
    fill(0);        run_group(256, 0, 0);
    run_group(255, 0, 0);
    run_group(-257, 0, 0);
    // Saturation both ways
    fill(1 << 23);  run_group(0, 0, 0);
    fill(-(1 << 23)); run_group(0, 0, 0);
    // Backpressure with products offered during OUT
    fill(512);      run_group(0, 0, 5);
    run_group(0, 0, 0);
    // Stalled group of alternating +/-1000
    foreach (prods[i]) prods[i] = (i % 2 == 0) ? 1000 : -1000;
    run_group(0, 100, 0);

    // Reset mid-group
    fill(512);
    for (int i = 0; i < 7; i++) send(512, 16'h0000);
    ap_rst = 1'b1;
    #1;
    check_value("midrst_busy", longint'(busy), 0);
    check_value("midrst_valid", longint'(res_valid), 0);
    check_value("midrst_ready", longint'(prod_ready), 0);
    @(posedge ap_clk); #2;
    ap_rst = 1'b0;
    #1;
    run_group(0, 0, 0);

    // Reset while a result is pending
    res_ready = 1'b0;
    for (int i = 0; i < N; i++) send(700, 16'h0000);
    check_value("out_valid", longint'(res_valid), 1);
    ap_rst = 1'b1;
    #1;
    check_value("outrst_valid", longint'(res_valid), 0);
    check_value("outrst_data", longint'(res_data), 0);
    check_value("outrst_busy", longint'(busy), 0);
    @(posedge ap_clk); #2;
    ap_rst = 1'b0;
    #1;
    fill(512); run_group(0, 0, 0);

    // Randomized groups
    for (int g = 0; g < 40; g++) begin
      range_sel = int'($urandom_range(2));
      rng = (range_sel == 0) ? (1 << 12) : (range_sel == 1) ? (1 << 20) : ((1 << 24) - 1);
      foreach (prods[i]) prods[i] = int'($urandom_range(0, 2 * rng)) - rng;
      rb = 16'($urandom);
      run_group(longint'($signed(rb)), 30, int'($urandom_range(3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
